// File: rtl/divisor_frec_timeout_pkg.sv
// Shared constants and elaboration helpers for the tick divider / idle-timeout block.
package divisor_pkg;

  localparam int unsigned BOARD_CLK_HZ      = 4_000_000;
  localparam int unsigned DEFAULT_TIMEOUT_S = 60;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned bits = 0;
    while ((64'd1 << bits) < value) bits++;
    return (bits < 1) ? 1 : bits;
  endfunction

  // Returns 0 on a zero tick rate so the caller's range check rejects it.
  function automatic int unsigned div_of(input int unsigned clk_hz, input int unsigned tick_hz);
    return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/divisor_frec_timeout_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, cleared by the async reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: state is updated with non-blocking assignments so both stages sample the pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= data_i;
      sync_q <= meta_q;
    end
  end

  assign data_o = sync_q;

endmodule

// File: rtl/divisor_frec_timeout.sv
// Clock-enable tick and square-wave generator plus button inactivity timeout,
// all in the clk_in domain; the timeout drives the display/game idle reset.
module divisor_frec_timeout
  import divisor_pkg::*;
#(
  parameter int unsigned CLK_HZ       = BOARD_CLK_HZ,
  parameter int unsigned TICK_HZ      = 1,
  parameter int unsigned N_BTN        = 3,
  parameter int unsigned TIMEOUT_S    = DEFAULT_TIMEOUT_S,
  parameter bit          AUTO_RESTART = 1'b1,
  parameter int unsigned SEC_W        = 6
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_BTN-1:0] btn,
  output logic             tick,
  output logic             clk_out,
  output logic             activity,
  output logic [SEC_W-1:0] secs_idle,
  output logic             timeout_pulse,
  output logic             timeout_flag
);

  localparam int unsigned DIV   = div_of(CLK_HZ, TICK_HZ);
  localparam int unsigned PRE_W = clog2(longint'(DIV));

  if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
    $error("divisor_frec_timeout: CLK_HZ/TICK_HZ must be even and at least 2");
  end
  if (TIMEOUT_S < 2) begin : g_bad_timeout
    $error("divisor_frec_timeout: TIMEOUT_S must be at least 2");
  end
  if ((64'd1 << SEC_W) <= 64'(TIMEOUT_S)) begin : g_bad_sec_w
    $error("divisor_frec_timeout: SEC_W too narrow to hold TIMEOUT_S");
  end

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(DIV / 2 - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TIMEOUT_S - 1);
  localparam logic [SEC_W-1:0] SEC_FULL = SEC_W'(TIMEOUT_S);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic             clk_out_q, clk_out_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic             flag_q, flag_d;
  logic             pulse_q, pulse_d;
  logic [N_BTN-1:0] btn_sync;

  sync_2ff #(.WIDTH(N_BTN)) u_btn_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .data_i (btn),
    .data_o (btn_sync)
  );

  assign activity = |btn_sync;
  // Gated by enable so a prescaler frozen on its last count yields exactly one tick.
  assign tick     = enable && (presc_q == PRE_LAST);

  // NOTE: every variable gets a default first so no path through always_comb infers a latch.
  always_comb begin
    presc_d   = presc_q;
    clk_out_d = clk_out_q;
    if (enable) begin
      presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
      if (presc_q == PRE_HALF || presc_q == PRE_LAST) clk_out_d = ~clk_out_q;
    end
  end

  // Activity outranks everything; tick already implies enable, so a frozen block just holds.
  always_comb begin
    secs_d  = secs_q;
    flag_d  = flag_q;
    pulse_d = 1'b0;
    if (activity) begin
      secs_d = '0;
      flag_d = 1'b0;
    end else if (tick) begin
      if (secs_q < SEC_LAST) begin
        secs_d = secs_q + 1'b1;
      end else if (secs_q == SEC_LAST) begin
        pulse_d = 1'b1;
        flag_d  = 1'b1;
        secs_d  = AUTO_RESTART ? '0 : SEC_FULL;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      clk_out_q <= 1'b0;
      secs_q    <= '0;
      flag_q    <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      clk_out_q <= clk_out_d;
      secs_q    <= secs_d;
      flag_q    <= flag_d;
      pulse_q   <= pulse_d;
    end
  end

  assign clk_out       = clk_out_q;
  assign secs_idle     = secs_q;
  assign timeout_pulse = pulse_q;
  assign timeout_flag  = flag_q;

endmodule
